// File: rtl/fifo_force_reducer.sv
// Read-side consumer for a force FIFO: sums runs of same-ID force contributions
// into one record and hands it downstream on a valid/ready handshake.
//
// state | meaning
// IDLE  | nothing pending; waiting for a FIFO word
// ACCUM | summing same-ID words into the accumulator
// EMIT  | record held on out_*; waiting for out_ready
module fifo_force_reducer #(
    parameter int ID_W   = 16,
    parameter int DATA_W = 48,
    parameter int CNT_W  = 8,
    parameter int SUM_W  = DATA_W + CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_W+DATA_W-1:0] fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_consume,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [SUM_W-1:0]       out_sum,
    output logic [CNT_W-1:0]       out_cnt,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    logic [ID_W-1:0]          acc_id;
    logic [SUM_W-1:0]         acc_sum;
    logic [CNT_W-1:0]         acc_cnt;

    logic [ID_W-1:0]          head_id;
    logic signed [DATA_W-1:0] head_force;
    logic [SUM_W-1:0]         head_sext;
    logic                     same_id;

    logic load_new;
    logic add_head;
    logic load_out;

    assign head_id    = fifo_data[ID_W+DATA_W-1:DATA_W];
    assign head_force = fifo_data[DATA_W-1:0];
    assign head_sext  = SUM_W'(head_force);
    assign same_id    = (head_id == acc_id);

    assign out_valid = (state == EMIT);
    assign busy      = (state == ACCUM) || (state == EMIT);

    always_comb begin
        state_nxt    = state;
        fifo_consume = 1'b0;
        load_new     = 1'b0;
        add_head     = 1'b0;
        load_out     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_consume = 1'b1;
                    load_new     = 1'b1;
                    state_nxt    = ACCUM;
                end
            end
            ACCUM: begin
                if (!fifo_empty) begin
                    if (same_id && (acc_cnt != CNT_MAX)) begin
                        fifo_consume = 1'b1;
                        add_head     = 1'b1;
                    end else begin
                        // ID change or full counter: the head word waits for the next record
                        load_out  = 1'b1;
                        state_nxt = EMIT;
                    end
                end else if (flush) begin
                    load_out  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_consume = 1'b1;
                        load_new     = 1'b1;
                        state_nxt    = ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            fifo_consume = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc_id  <= '0;
            acc_sum <= '0;
            acc_cnt <= '0;
            out_id  <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_new) begin
                acc_id  <= head_id;
                acc_sum <= head_sext;
                acc_cnt <= CNT_W'(1);
            end else if (add_head) begin
                acc_sum <= acc_sum + head_sext;
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (load_out) begin
                out_id  <= acc_id;
                out_sum <= acc_sum;
                out_cnt <= acc_cnt;
            end
        end
    end

endmodule

// File: doc/fifo_force_reducer.md
Name: fifo_force_reducer

Overview:
- Read-side consumer for the general-purpose FIFO: watches `empty`, samples the FIFO's combinational `out` word and drives `consume`.
- Each entry is one partial force contribution tagged with a particle ID.
- Runs of consecutive entries with the same ID are summed into one record, emitted downstream on a valid/ready handshake.
- Sits between the per-pipeline force FIFOs and the force write-back / position-update stage.

Parameters:
- ID_W, 16, particle ID width; ID occupies upper bits of the FIFO word.
- DATA_W, 48, signed two's-complement force width; lower bits of the FIFO word.
- CNT_W, 8, contribution-counter width; max run length per record is 2^CNT_W-1.
- SUM_W, DATA_W+CNT_W, accumulator width; guarantees no overflow.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- fifo_data  input  ID_W+DATA_W  FIFO head word {id, force}; valid whenever fifo_empty=0
- fifo_empty  input  1  FIFO empty flag
- fifo_consume  output  1  pop strobe to FIFO; head advances at the next posedge
- flush  input  1  level; forces emission of a pending record once the FIFO is empty
- out_valid  output  1  result record valid
- out_ready  input  1  downstream accepts record
- out_id  output  ID_W  particle ID of record
- out_sum  output  SUM_W  sign-extended sum of contributions
- out_cnt  output  CNT_W  number of contributions summed (>=1)
- busy  output  1  high in ACCUM or EMIT

Behaviour:
- Clock and reset: one clock; synchronous active-high reset.
- Reset values: state=IDLE, out_valid=0, out_id=0, out_sum=0, out_cnt=0, accumulator/counter=0.
- fifo_consume is combinational and must be 0 whenever rst=1.
- Reset mid-operation discards any partial sum. No record is emitted for it.
- Pop rule: fifo_consume=1 only when fifo_empty=0. The word is taken from fifo_data in the same cycle fifo_consume is high. Never pop a word that is not absorbed.
- IDLE:
  - fifo_empty=0 -> consume=1; acc_id<=id; acc_sum<=sext(force); acc_cnt<=1; go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM:
  - fifo_empty=0, id==acc_id and acc_cnt<2^CNT_W-1 -> consume=1; acc_sum<=acc_sum+sext(force); acc_cnt<=acc_cnt+1.
  - fifo_empty=0 and id!=acc_id -> no pop; load output regs from accumulator; go to EMIT.
  - fifo_empty=0, id==acc_id and acc_cnt==2^CNT_W-1 -> no pop; load output regs; go to EMIT. The same-ID word starts a new record later.
  - fifo_empty=1 and flush=1 -> load output regs; go to EMIT.
  - fifo_empty=1 and flush=0 -> hold.
- EMIT:
  - out_valid=1. out_id/out_sum/out_cnt are stable until accepted.
  - out_ready=1 and fifo_empty=0 -> record accepted; consume=1; new record loaded from the head word; go to ACCUM. Zero-bubble.
  - out_ready=1 and fifo_empty=1 -> out_valid<=0; go to IDLE.
  - out_ready=0 -> hold; no pops.
- Latency:
  - First pop occurs in the same cycle the FIFO reports non-empty while in IDLE.
  - A record appears on out_valid one cycle after the terminating condition (ID change, count limit, or flush with empty) is seen.
- Throughput: one FIFO word per cycle while accumulating. In EMIT with out_ready=1, one pop plus one emission per cycle.
- Arithmetic: force is sign-extended to SUM_W. Addition is modulo-free by construction because of SUM_W.
- Simultaneous flush with a non-empty FIFO: flush is ignored until the FIFO is empty. Flush while IDLE has no effect.

Test Plan:
- Single entry: preload {id=5, force=+100}, flush=1, out_ready=1 -> exactly one record id=5, sum=100, cnt=1; fifo_consume pulses once; returns to IDLE, busy=0.
- Same-ID run: entries id=3 with forces +10, -4, +7, -20, then id=9 force 1; flush after drain -> records (3, -7, 4) then (9, 1, 1); no consume on the cycle the ID change is detected.
- Backpressure: hold out_ready=0 for 10 cycles in EMIT with FIFO non-empty -> out_* stable, fifo_consume=0 throughout. On out_ready=1 the next word is popped the same cycle.
- Count limit: CNT_W=3, nine entries id=1 force=-1 -> records (1, -7, 7) then (1, -2, 2) after flush; extreme negative force -2^47 x7 yields sum -7*2^47 without wrap.
- Empty/flush corner: FIFO empty with flush=0 in ACCUM for 20 cycles -> no output, no pops. Then flush=1 -> record emitted next cycle.
- Reset mid-run: assert rst after 2 of 4 same-ID pops -> out_valid=0, fifo_consume=0 during reset, state IDLE. The next words form fresh records with no partial residue.
